// File: rtl/counter_hs_driver_if.sv
// rtl/counter_hs_driver_if.sv - four-phase request/acknowledge channels between driver and counter

interface counter_hs_driver_if;
   logic ri;
   logic ai;
   logic ro;
   logic ao;

   modport master (output ri, output ao, input ai, input ro);
   modport slave  (input ri, input ao, output ai, output ro);
endinterface

// File: rtl/counter_hs_driver.sv
// rtl/counter_hs_driver.sv - drives n_req four-phase input handshakes into a counter, acks its outputs
// and counts both sides, with per-edge timeout.

module counter_hs_driver #(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 1023
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_start,
   input  logic [CNT_W-1:0]     i_n_req,
   counter_hs_driver_if.master  hs,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_err,
   output logic [CNT_W-1:0]     o_in_cnt,
   output logic [CNT_W-1:0]     o_out_cnt
);

   localparam int               TMO_W    = $clog2(TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [2:0] {
      IDLE,
      REQ_UP,
      REQ_DN,
      DRAIN,
      DONE,
      ERR
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [SYNC_STAGES-1:0] r_ai_sync;
   logic [SYNC_STAGES-1:0] r_ro_sync;
   logic [TMO_W-1:0]       r_tmo;
   logic [CNT_W-1:0]       r_n_req;
   logic [CNT_W-1:0]       r_in_cnt;
   logic [CNT_W-1:0]       r_out_cnt;
   logic                   r_ri;
   logic                   r_ao;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_err;

   logic                   w_ai_s;
   logic                   w_ro_s;
   logic                   w_accept;
   logic                   w_in_inc;
   logic                   w_out_inc;
   logic                   w_tmo_hit;
   logic                   w_busy_st;
   logic [CNT_W-1:0]       w_in_cnt_inc;
   logic [CNT_W-1:0]       w_out_cnt_inc;

   // ai/ro come from the counter's own timing domain; nothing else may look at them raw
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ai_sync <= '0;
         r_ro_sync <= '0;
      end else begin
         r_ai_sync <= {r_ai_sync[SYNC_STAGES-2:0], hs.ai};
         r_ro_sync <= {r_ro_sync[SYNC_STAGES-2:0], hs.ro};
      end
   end

   assign w_ai_s        = r_ai_sync[SYNC_STAGES-1];
   assign w_ro_s        = r_ro_sync[SYNC_STAGES-1];
   assign w_tmo_hit     = (r_tmo == TMO_LAST);
   assign w_busy_st     = (r_state == REQ_UP) || (r_state == REQ_DN) || (r_state == DRAIN);
   assign w_in_cnt_inc  = (r_in_cnt == CNT_MAX) ? r_in_cnt : r_in_cnt + 1'b1;
   assign w_out_cnt_inc = (r_out_cnt == CNT_MAX) ? r_out_cnt : r_out_cnt + 1'b1;
   assign w_out_inc     = w_ro_s && !r_ao && (r_state != IDLE) && (r_state != ERR);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Handshake progress takes priority over the timeout on the same cycle
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_in_inc    = 1'b0;
      case (r_state)
         IDLE, ERR: begin
            if (i_start) begin
               w_accept    = 1'b1;
               w_state_nxt = (i_n_req != '0) ? REQ_UP : DONE;
            end
         end
         REQ_UP: begin
            if (w_ai_s) begin
               w_state_nxt = REQ_DN;
            end else if (w_tmo_hit) begin
               w_state_nxt = ERR;
            end
         end
         REQ_DN: begin
            if (!w_ai_s) begin
               w_in_inc    = 1'b1;
               w_state_nxt = (w_in_cnt_inc < r_n_req) ? REQ_UP : DRAIN;
            end else if (w_tmo_hit) begin
               w_state_nxt = ERR;
            end
         end
         DRAIN: begin
            if (!w_ro_s && !r_ao) begin
               w_state_nxt = DONE;
            end else if (w_tmo_hit) begin
               w_state_nxt = ERR;
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_tmo <= '0;
      end else if (w_state_nxt != r_state) begin
         r_tmo <= '0;
      end else if (w_busy_st) begin
         r_tmo <= r_tmo + 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_n_req   <= '0;
         r_in_cnt  <= '0;
         r_out_cnt <= '0;
      end else if (w_accept) begin
         r_n_req   <= i_n_req;
         r_in_cnt  <= '0;
         r_out_cnt <= '0;
      end else begin
         if (w_in_inc) begin
            r_in_cnt <= w_in_cnt_inc;
         end
         if (w_out_inc) begin
            r_out_cnt <= w_out_cnt_inc;
         end
      end
   end

   // Outputs decode the current state one edge later, so ri rises the edge after start is taken
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ri   <= 1'b0;
         r_ao   <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         r_ri   <= (r_state == REQ_UP);
         r_ao   <= w_ro_s;
         r_busy <= w_busy_st;
         r_done <= (r_state == DONE);
         r_err  <= (r_state == ERR);
      end
   end

   assign hs.ri     = r_ri;
   assign hs.ao     = r_ao;
   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_err     = r_err;
   assign o_in_cnt  = r_in_cnt;
   assign o_out_cnt = r_out_cnt;

endmodule

// File: tb/tb_counter_hs_driver.sv
// tb/tb_counter_hs_driver.sv - directed bench for counter_hs_driver with a 3-cycle acknowledging counter model

module tb_counter_hs_driver;

   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [CNT_W-1:0] n_req = '0;
   logic             busy;
   logic             done;
   logic             err;
   logic [CNT_W-1:0] in_cnt;
   logic [CNT_W-1:0] out_cnt;

   int n_cmp = 0;
   int n_fail = 0;

   logic model_en = 1'b0;
   int   model_cnt = 0;
   int   hs_cycles = 0;
   int   done_pulses = 0;

   counter_hs_driver_if hs_if ();

   counter_hs_driver #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (2),
      .TIMEOUT     (15)
   ) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_start   (start),
      .i_n_req   (n_req),
      .hs        (hs_if),
      .o_busy    (busy),
      .o_done    (done),
      .o_err     (err),
      .o_in_cnt  (in_cnt),
      .o_out_cnt (out_cnt)
   );

   always #5 clk = ~clk;

   // Counter input channel: answers any ri change after 3 cycles
   always @(negedge clk) begin
      if (!model_en) begin
         hs_if.ai = 1'b0;
         model_cnt = 0;
      end else if (hs_if.ri !== hs_if.ai) begin
         model_cnt = model_cnt + 1;
         if (model_cnt == 3) begin
            if (hs_if.ai === 1'b1) hs_cycles = hs_cycles + 1;
            hs_if.ai = hs_if.ri;
            model_cnt = 0;
         end
      end else begin
         model_cnt = 0;
      end
   end

   always @(negedge clk) begin
      if (done === 1'b1) done_pulses = done_pulses + 1;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic issue_start(input logic [CNT_W-1:0] n);
      @(negedge clk);
      start = 1'b1;
      n_req = n;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int max, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < max && !seen; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      tick(3);
      n_cmp++;
      if ({hs_if.ri, hs_if.ao, busy, done, err} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_flags got %b want 00000", {hs_if.ri, hs_if.ao, busy, done, err});
      end
      n_cmp++;
      if ({in_cnt, out_cnt} !== '0) begin
         n_fail++;
         $display("FAIL reset_counts got %0d/%0d want 0/0", in_cnt, out_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick(2);
   endtask

   task automatic test_run4;
      int  c0, d0;
      bit  seen;
      model_en = 1'b1;
      tick(2);
      c0 = hs_cycles;
      d0 = done_pulses;
      issue_start(4);
      n_cmp++;
      if (hs_if.ri !== 1'b0) begin
         n_fail++;
         $display("FAIL run4_ri_early got %b want 0", hs_if.ri);
      end
      tick(1);
      n_cmp++;
      if ({hs_if.ri, busy} !== 2'b11) begin
         n_fail++;
         $display("FAIL run4_ri_busy_rise got %b want 11", {hs_if.ri, busy});
      end
      wait_done(300, seen);
      n_cmp++;
      if (!seen) begin
         n_fail++;
         $display("FAIL run4_done_seen got 0 want 1");
      end
      n_cmp++;
      if (in_cnt !== 16'd4) begin
         n_fail++;
         $display("FAIL run4_in_cnt got %0d want 4", in_cnt);
      end
      n_cmp++;
      if ({busy, err} !== 2'b00) begin
         n_fail++;
         $display("FAIL run4_busy_err got %b want 00", {busy, err});
      end
      tick(3);
      n_cmp++;
      if (done_pulses - d0 !== 1) begin
         n_fail++;
         $display("FAIL run4_done_pulses got %0d want 1", done_pulses - d0);
      end
      n_cmp++;
      if (hs_cycles - c0 !== 4) begin
         n_fail++;
         $display("FAIL run4_hs_cycles got %0d want 4", hs_cycles - c0);
      end
      n_cmp++;
      if ({hs_if.ri, busy, in_cnt} !== {2'b00, 16'd4}) begin
         n_fail++;
         $display("FAIL run4_hold got ri=%b busy=%b in=%0d want 0 0 4", hs_if.ri, busy, in_cnt);
      end
   endtask

   task automatic test_zero;
      @(negedge clk);
      start = 1'b1;
      n_req = '0;
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_done_early got %b want 0", done);
      end
      @(negedge clk);
      n_cmp++;
      if ({done, hs_if.ri, busy} !== 3'b100) begin
         n_fail++;
         $display("FAIL zero_done_pulse got %b want 100", {done, hs_if.ri, busy});
      end
      @(negedge clk);
      n_cmp++;
      if ({done, hs_if.ri, busy} !== 3'b000) begin
         n_fail++;
         $display("FAIL zero_after got %b want 000", {done, hs_if.ri, busy});
      end
   endtask

   task automatic test_timeout;
      int cycles;
      bit seen;
      model_en = 1'b0;
      tick(2);
      issue_start(5);
      tick(1);
      n_cmp++;
      if (hs_if.ri !== 1'b1) begin
         n_fail++;
         $display("FAIL tmo_ri_rise got %b want 1", hs_if.ri);
      end
      cycles = 0;
      while (cycles < 20 && err !== 1'b1) begin
         @(negedge clk);
         cycles++;
      end
      n_cmp++;
      if (err !== 1'b1 || cycles > 16) begin
         n_fail++;
         $display("FAIL tmo_err_latency got err=%b after %0d cycles want 1 within 16", err, cycles);
      end
      n_cmp++;
      if ({hs_if.ri, busy, in_cnt} !== {2'b00, 16'd0}) begin
         n_fail++;
         $display("FAIL tmo_state got ri=%b busy=%b in=%0d want 0 0 0", hs_if.ri, busy, in_cnt);
      end
      tick(4);
      n_cmp++;
      if (err !== 1'b1) begin
         n_fail++;
         $display("FAIL tmo_err_sticky got %b want 1", err);
      end
      model_en = 1'b1;
      issue_start(2);
      tick(1);
      n_cmp++;
      if ({err, busy, hs_if.ri} !== 3'b011) begin
         n_fail++;
         $display("FAIL tmo_restart got err/busy/ri=%b want 011", {err, busy, hs_if.ri});
      end
      wait_done(200, seen);
      n_cmp++;
      if (!seen || in_cnt !== 16'd2 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL tmo_rerun got seen=%b in=%0d err=%b want 1 2 0", seen, in_cnt, err);
      end
   endtask

   task automatic test_out_cnt;
      bit seen;
      model_en = 1'b1;
      tick(2);
      issue_start(8);
      fork
         begin
            for (int k = 0; k < 3; k++) begin
               hs_if.ro = 1'b1;
               if (k == 0) begin
                  tick(2);
                  n_cmp++;
                  if (hs_if.ao !== 1'b0) begin
                     n_fail++;
                     $display("FAIL out_ao_early got %b want 0", hs_if.ao);
                  end
                  tick(1);
                  n_cmp++;
                  if (hs_if.ao !== 1'b1) begin
                     n_fail++;
                     $display("FAIL out_ao_delay3 got %b want 1", hs_if.ao);
                  end
                  tick(3);
               end else begin
                  tick(6);
               end
               hs_if.ro = 1'b0;
               tick(6);
            end
         end
         begin
            wait_done(400, seen);
         end
      join
      n_cmp++;
      if (!seen || out_cnt !== 16'd3) begin
         n_fail++;
         $display("FAIL out_cnt got seen=%b out=%0d want 1 3", seen, out_cnt);
      end
      n_cmp++;
      if (in_cnt !== 16'd8) begin
         n_fail++;
         $display("FAIL out_in_cnt got %0d want 8", in_cnt);
      end
   endtask

   task automatic test_busy_start;
      bit seen;
      issue_start(3);
      tick(4);
      repeat (2) begin
         @(negedge clk);
         start = 1'b1;
         n_req = 16'd7;
         @(negedge clk);
         start = 1'b0;
         tick(3);
      end
      wait_done(300, seen);
      n_cmp++;
      if (!seen || in_cnt !== 16'd3) begin
         n_fail++;
         $display("FAIL busy_start_n_req got seen=%b in=%0d want 1 3", seen, in_cnt);
      end
      issue_start(1);
      wait_done(100, seen);
      n_cmp++;
      if (!seen || in_cnt !== 16'd1 || out_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL back_to_back got seen=%b in=%0d out=%0d want 1 1 0", seen, in_cnt, out_cnt);
      end
   endtask

   task automatic test_reset_mid_run;
      int  guard;
      model_en = 1'b1;
      tick(2);
      issue_start(6);
      guard = 0;
      while (guard < 100 && in_cnt !== 16'd1) begin
         @(negedge clk);
         guard++;
      end
      guard = 0;
      while (guard < 100 && hs_if.ai !== 1'b1) begin
         @(negedge clk);
         #1;
         guard++;
      end
      tick(3);
      n_cmp++;
      if ({hs_if.ri, in_cnt} !== {1'b1, 16'd1}) begin
         n_fail++;
         $display("FAIL rst_pre got ri=%b in=%0d want 1 1", hs_if.ri, in_cnt);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({hs_if.ri, busy, in_cnt, out_cnt} !== '0) begin
         n_fail++;
         $display("FAIL rst_async got ri=%b busy=%b in=%0d out=%0d want 0", hs_if.ri, busy, in_cnt, out_cnt);
      end
      tick(2);
      rst_n = 1'b1;
      tick(20);
      n_cmp++;
      if ({hs_if.ri, busy, done, in_cnt} !== '0) begin
         n_fail++;
         $display("FAIL rst_no_resume got ri=%b busy=%b done=%b in=%0d want 0", hs_if.ri, busy, done, in_cnt);
      end
   endtask

   initial begin
      hs_if.ro = 1'b0;
      test_reset();
      test_run4();
      test_zero();
      test_timeout();
      test_out_cnt();
      test_busy_start();
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired after %0d compared", n_cmp);
      $fatal(1);
   end

endmodule

// File: doc/counter_hs_driver.md
COUNTER_HS_DRIVER -- requirements
Module: counter_hs_driver

Interface
REQ-001 Parameter CNT_W, 16, width of request and count fields.
REQ-002 Parameter SYNC_STAGES, 2, flop depth of each input synchronizer; legal range 2..4.
REQ-003 Parameter TIMEOUT, 1023, maximum cycles spent waiting on one handshake edge before error.
REQ-004 clk  in  1  single system clock; all flops rising-edge.
REQ-005 rst_n  in  1  reset; asynchronous, active-low.
REQ-006 start  in  1  one-cycle command to begin a run.
REQ-007 n_req  in  CNT_W  number of input handshakes to issue; sampled with an accepted start.
REQ-008 ri  out  1  request to the counter input channel.
REQ-009 ai  in  1  acknowledge from the counter input channel; asynchronous.
REQ-010 ro  in  1  request from the counter output channel; asynchronous.
REQ-011 ao  out  1  acknowledge to the counter output channel.
REQ-012 busy  out  1  high while a run is in progress.
REQ-013 done  out  1  one-cycle pulse at successful run completion.
REQ-014 err  out  1  sticky timeout flag.
REQ-015 in_cnt  out  CNT_W  input handshakes completed in the current run.
REQ-016 out_cnt  out  CNT_W  output handshakes observed in the current run.

Function
REQ-017 ai and ro SHALL each pass through a SYNC_STAGES-deep synchronizer; ai_s and ro_s denote the synchronized values, and no other logic SHALL sample ai or ro directly.
REQ-018 The FSM SHALL have states IDLE, REQ_UP, REQ_DN, DRAIN, DONE, ERR; ri, ao, busy, done, err SHALL be registered outputs.
REQ-019 IDLE: start=1 with n_req>0 SHALL go to REQ_UP, clear in_cnt, out_cnt and the timeout counter, and latch n_req; start=1 with n_req=0 SHALL go to DONE.
REQ-020 REQ_UP: ri=1; ai_s=1 SHALL go to REQ_DN.
REQ-021 REQ_DN: ri=0; ai_s=0 SHALL increment in_cnt, then go to REQ_UP if the new in_cnt is below the latched n_req, otherwise go to DRAIN.
REQ-022 DRAIN: ri=0; ro_s=0 and ao=0 on the same cycle SHALL go to DONE.
REQ-023 DONE: done=1 for exactly one cycle; the next state SHALL be IDLE.
REQ-024 Latency: ri SHALL rise on the first clk edge after the edge that accepts start; each handshake edge SHALL take at least SYNC_STAGES+1 cycles.
REQ-025 busy SHALL be 1 in REQ_UP, REQ_DN and DRAIN, and 0 otherwise.
REQ-026 start SHALL be ignored in every state except IDLE and ERR.
REQ-027 ao SHALL follow ro_s one cycle later in every state, including IDLE and ERR, so that the counter never deadlocks.
REQ-028 out_cnt SHALL increment on each cycle where ro_s=1 and ao=0 (ao rising), in all states except IDLE and ERR.
REQ-029 in_cnt and out_cnt SHALL saturate at 2^CNT_W-1 and SHALL hold their values after DONE until the next accepted start.
REQ-030 The timeout counter SHALL clear on every state change and increment on each cycle spent in REQ_UP, REQ_DN or DRAIN.
REQ-031 Reaching TIMEOUT SHALL go to ERR: err=1, ri=0, busy=0, and the counts SHALL freeze.
REQ-032 ERR: start=1 SHALL clear err and then behave as an accepted start from IDLE.

Reset
REQ-033 rst_n=0 SHALL asynchronously force state IDLE, set ri, ao, busy, done, err to 0, set in_cnt, out_cnt and the timeout counter to 0, and clear all synchronizer flops.
REQ-034 Reset asserted mid-run SHALL drop ri immediately; after reset release the block SHALL be in IDLE awaiting start, with no resumption of the interrupted run.

Verification
REQ-035 Bench: counter model acknowledges in 3 cycles; start with n_req=4 -> four complete ri/ai four-phase cycles, in_cnt=4, one done pulse, busy low afterwards, err=0.
REQ-036 Bench: n_req=0 -> done pulses 2 cycles after start, ri stays 0, busy stays 0.
REQ-037 Bench: ai held at 0, TIMEOUT=15 -> err=1 within 16 cycles of ri rising, ri=0, in_cnt=0; a subsequent start clears err and begins a new run.
REQ-038 Bench: ro toggled 3 times during a run with n_req=8 -> ao mirrors ro with SYNC_STAGES+1 cycles of delay, and out_cnt=3 at done.
REQ-039 Bench: rst_n pulsed low while in REQ_DN -> ri=0 and counts=0 in the same cycle; extra start pulses applied while busy=1 do not change the latched n_req.
